clk_div_multi: RTL and testbench
================================

// Module: clk_div_multi
// PURPOSE
//  Parametrised N-channel clock divider: successor to the single fixed-ratio divider.
//  Each channel produces a toggled divided clock plus a 1-cycle tick strobe from clk_in.
//  Divisors are runtime-programmable through a shadow register, applied glitch-free at period end.
//  A sync strobe phase-aligns all channels. Sits in the clocking/timebase area feeding LEDs, UART, PWM.
// PARAMETERS
//  NCH      4        number of channels (1..16)
//  DIV_W    19       divisor/counter width in bits
//  DEF_DIV  250000   reset half-period divisor for every channel (must fit DIV_W)
//  CH_W     $clog2(NCH) (min 1)  channel-select width, derived, not overridden
// PORTS
//  clk_in    in   1          single system clock
//  reset_n   in   1          asynchronous, active-low reset
//  ch_en     in   NCH        per-channel run enable
//  sync_all  in   1          1-cycle strobe: restart all channels in phase
//  cfg_wr    in   1          write strobe for divisor shadow
//  cfg_ch    in   CH_W       target channel of cfg_wr
//  cfg_div   in   DIV_W      new half-period divisor D
//  clk_out   out  NCH        divided clocks, period 2*D clk_in cycles, 50% duty
//  tick      out  NCH        1-cycle pulse at each clk_out toggle
//  cfg_pend  out  NCH        shadow written but not yet applied
// BEHAVIOUR
//  - Reset (reset_n=0, async): count=0, active=shadow=DEF_DIV, clk_out=0, tick=0, cfg_pend=0.
//  - Per channel, enabled: count runs 0..D-1; at count==D-1 (terminal): count<=0, clk_out<=~clk_out,
//    tick<=1 for exactly that next cycle. First toggle D cycles after enable rises.
//  - D==0 written is treated as D=1 (toggle every cycle); never stalls.
//  - Disabled (ch_en=0): count<=0, clk_out<=0, tick<=0 next edge; shadow still writable.
//  - cfg_wr: shadow[cfg_ch]<=cfg_div, cfg_pend[cfg_ch]<=1. cfg_ch>=NCH: write ignored.
//  - Apply: at terminal count active<=shadow, cfg_pend<=0; new D governs the next half-period.
//    Disabled channel applies on the following cycle (pend high exactly 1 cycle).
//  - Simultaneous cfg_wr and terminal count on same channel: cfg_div goes straight into active
//    and shadow; cfg_pend stays 0.
//  - Back-to-back writes before apply: last write wins.
//  - sync_all: every channel count<=0, clk_out<=0, tick<=0 and pending shadows applied, same edge.
//    Priority per channel: reset_n > sync_all > ch_en=0 > terminal count > increment.
//  - Registered outputs only; no combinational path input->output. No clock gating;
//    clk_out is a fabric signal (use tick as enable where possible).
//  - Width: count compare uses active-1 in DIV_W bits; count never exceeds active-1
//    even if active shrinks mid-period (apply only at terminal, so guaranteed).
// STRUCTURE
//  - Package clk_div_pkg: DEF_DIV default, DIV_W default, clog2-min-1 helper function.
//  - Sub-module clk_div_channel (one per channel, generate loop): count, active, shadow,
//    clk_out, tick, pend; inputs en, sync, wr, wdata.
//  - Top: cfg_ch decode to per-channel wr, generate instantiation, output packing.
// TESTING
//  1. Reset, DEF_DIV=4 override, ch_en=1 -> clk_out[0] toggles every 4 cycles, tick once per 4.
//  2. Ch0 D=3, cfg_wr ch0 D=5 mid-period -> cfg_pend=1 until terminal, then half-period 5, no runt.
//  3. cfg_wr with D=0 -> clk_out toggles every cycle; cfg_ch=NCH (NCH=3) -> no channel changes.
//  4. Ch0 D=2, ch1 D=6, sync_all -> both clk_out=0, counts 0; rising edges realign every 12 cycles.
//  5. cfg_wr coincident with terminal count -> new D used immediately, cfg_pend never asserts.
//  6. reset_n low mid-period (async, between edges) -> all outputs 0 immediately, active=DEF_DIV.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package clk_div_pkg;

    // Default divisor/counter width and reset half-period divisor
    localparam int DIV_W_DEFAULT   = 19;
    localparam int DEF_DIV_DEFAULT = 250000;
    localparam int NCH_DEFAULT     = 4;

    // Width needed to index n items, never less than one bit
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter, active/shadow divisor, divided clock and tick.
// Latency: outputs registered; first toggle D cycles after enable, sync/disable take effect next edge.
// Backpressure: none; free-running, divisor writes are always accepted into the shadow.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEFAULT,
    parameter int DEF_DIV = DEF_DIV_DEFAULT
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_wr,
    input  logic [DIV_W-1:0] i_wdata,
    output logic             o_clk,
    output logic             o_tick,
    output logic             o_pend
);

    localparam logic [DIV_W-1:0] DEF_VAL = DIV_W'(DEF_DIV);

    logic [DIV_W-1:0] r_count;
    logic [DIV_W-1:0] r_active;
    logic [DIV_W-1:0] r_shadow;
    logic             r_clk;
    logic             r_tick;
    logic             r_pend;

    logic [DIV_W-1:0] w_last;
    logic             w_term;

    // A zero divisor behaves as one, so the terminal value never underflows
    assign w_last = (r_active == '0) ? '0 : (r_active - DIV_W'(1));
    // Active only changes at terminal count, so count never passes w_last
    assign w_term = (r_count == w_last);

    // Channel state: sync beats disable beats terminal count beats increment
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_count  <= '0;
            r_active <= DEF_VAL;
            r_shadow <= DEF_VAL;
            r_clk    <= 1'b0;
            r_tick   <= 1'b0;
            r_pend   <= 1'b0;
        end else if (i_sync) begin
            // Restart in phase; a write landing on the same edge is taken as the new divisor
            r_count <= '0;
            r_clk   <= 1'b0;
            r_tick  <= 1'b0;
            r_pend  <= 1'b0;
            if (i_wr) begin
                r_active <= i_wdata;
                r_shadow <= i_wdata;
            end else if (r_pend) begin
                r_active <= r_shadow;
            end
        end else if (!i_en) begin
            // Idle channel: hold low, apply a pending divisor one cycle after it was written
            r_count <= '0;
            r_clk   <= 1'b0;
            r_tick  <= 1'b0;
            if (i_wr) begin
                r_shadow <= i_wdata;
                r_pend   <= 1'b1;
            end else if (r_pend) begin
                r_active <= r_shadow;
                r_pend   <= 1'b0;
            end
        end else if (w_term) begin
            // Period boundary: toggle, strobe, and switch divisor without a runt half-period
            r_count <= '0;
            r_clk   <= ~r_clk;
            r_tick  <= 1'b1;
            r_pend  <= 1'b0;
            if (i_wr) begin
                r_active <= i_wdata;
                r_shadow <= i_wdata;
            end else begin
                r_active <= r_shadow;
            end
        end else begin
            r_count <= r_count + DIV_W'(1);
            r_tick  <= 1'b0;
            if (i_wr) begin
                r_shadow <= i_wdata;
                r_pend   <= 1'b1;
            end
        end
    end

    assign o_clk  = r_clk;
    assign o_tick = r_tick;
    assign o_pend = r_pend;

endmodule

// File: rtl/clk_div_multi.sv
// N-channel programmable clock divider with per-channel tick strobes and global phase sync.
// Latency: all outputs registered; config write visible on cfg_pend one edge later.
// Backpressure: none; writes to out-of-range channels are silently dropped.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NCH     = NCH_DEFAULT,
    parameter int DIV_W   = DIV_W_DEFAULT,
    parameter int DEF_DIV = DEF_DIV_DEFAULT
) (
    input  logic                        clk_in,
    input  logic                        reset_n,
    input  logic [NCH-1:0]              ch_en,
    input  logic                        sync_all,
    input  logic                        cfg_wr,
    input  logic [clog2_min1(NCH)-1:0]  cfg_ch,
    input  logic [DIV_W-1:0]            cfg_div,
    output logic [NCH-1:0]              clk_out,
    output logic [NCH-1:0]              tick,
    output logic [NCH-1:0]              cfg_pend
);

    localparam int CH_W = clog2_min1(NCH);

    logic [NCH-1:0] w_wr;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        // Channel select decode; indices at or above NCH match no channel
        assign w_wr[g] = cfg_wr && (cfg_ch == CH_W'(g));

        clk_div_channel #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk_in  (clk_in),
            .reset_n (reset_n),
            .i_en    (ch_en[g]),
            .i_sync  (sync_all),
            .i_wr    (w_wr[g]),
            .i_wdata (cfg_div),
            .o_clk   (clk_out[g]),
            .o_tick  (tick[g]),
            .o_pend  (cfg_pend[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed scenarios plus randomized traffic.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_clk_div_multi;

    localparam int NCH     = 3;
    localparam int DIV_W   = 8;
    localparam int DEF_DIV = 4;
    localparam int CH_W    = 2;

    logic             clk_in = 1'b0;
    logic             reset_n;
    logic [NCH-1:0]   ch_en;
    logic             sync_all;
    logic             cfg_wr;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   cfg_pend;

    int vectors;
    int miscompares;

    // Reference model: each half-period is tracked by the edge index at which it started
    logic [NCH-1:0] m_clk, m_tick, m_pend;
    int             m_act   [NCH];
    int             m_shad  [NCH];
    int             m_start [NCH];
    int             m_t;    // index of the next rising edge

    clk_div_multi #(.NCH(NCH), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) dut (
        .clk_in   (clk_in),
        .reset_n  (reset_n),
        .ch_en    (ch_en),
        .sync_all (sync_all),
        .cfg_wr   (cfg_wr),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .clk_out  (clk_out),
        .tick     (tick),
        .cfg_pend (cfg_pend)
    );

    always #5 clk_in = ~clk_in;

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_act[c]   = DEF_DIV;
            m_shad[c]  = DEF_DIV;
            m_start[c] = m_t;
        end
        m_clk  = '0;
        m_tick = '0;
        m_pend = '0;
    endtask

    // Advance the model by one edge using the inputs presented at that edge
    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            bit wr_c;
            wr_c = cfg_wr && (int'(cfg_ch) == c);
            m_tick[c] = 1'b0;
            if (sync_all) begin
                m_clk[c]   = 1'b0;
                m_start[c] = m_t + 1;
                if (wr_c) begin
                    m_act[c]  = int'(cfg_div);
                    m_shad[c] = int'(cfg_div);
                end else if (m_pend[c]) begin
                    m_act[c] = m_shad[c];
                end
                m_pend[c] = 1'b0;
            end else if (!ch_en[c]) begin
                m_clk[c]   = 1'b0;
                m_start[c] = m_t + 1;
                if (wr_c) begin
                    m_shad[c] = int'(cfg_div);
                    m_pend[c] = 1'b1;
                end else if (m_pend[c]) begin
                    m_act[c]  = m_shad[c];
                    m_pend[c] = 1'b0;
                end
            end else if (m_t - m_start[c] + 1 >= eff(m_act[c])) begin
                m_clk[c]   = ~m_clk[c];
                m_tick[c]  = 1'b1;
                m_start[c] = m_t + 1;
                m_act[c]   = wr_c ? int'(cfg_div) : m_shad[c];
                m_shad[c]  = m_act[c];
                m_pend[c]  = 1'b0;
            end else if (wr_c) begin
                m_shad[c] = int'(cfg_div);
                m_pend[c] = 1'b1;
            end
        end
        m_t++;
    endtask

    task automatic step();
        @(posedge clk_in);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        vectors++;
        if ({clk_out, tick, cfg_pend} !== '0) begin
            miscompares++;
            $display("FAIL reset_state got %b want 0", {clk_out, tick, cfg_pend});
        end
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        int ticks;
        ticks = 0;
        ch_en = 3'b001;
        for (int i = 0; i < 40; i++) begin
            step();
            vectors++;
            if ({clk_out, tick, cfg_pend} !== {m_clk, m_tick, m_pend}) begin
                miscompares++;
                $display("FAIL basic t=%0d got %b want %b", m_t, {clk_out, tick, cfg_pend}, {m_clk, m_tick, m_pend});
            end
            if (tick[0]) ticks++;
        end
        vectors++;
        if (ticks !== 10) begin
            miscompares++;
            $display("FAIL basic_tick_count got %0d want 10", ticks);
        end
    endtask

    task automatic test_reconfig();
        int gap;
        bit found;
        cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd3;
        step();
        cfg_wr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            vectors++;
            if ({clk_out, tick, cfg_pend} !== {m_clk, m_tick, m_pend}) begin
                miscompares++;
                $display("FAIL reconfig_d3 t=%0d got %b want %b", m_t, {clk_out, tick, cfg_pend}, {m_clk, m_tick, m_pend});
            end
        end
        // Land the next write one edge into a half-period
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_t - m_start[0] == 1) found = 1'b1;
            else step();
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL reconfig_align timeout got 0 want 1");
        end
        cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd5;
        step();
        cfg_wr = 1'b0;
        vectors++;
        if (cfg_pend[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL reconfig_pend got %b want 1", cfg_pend[0]);
        end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            vectors++;
            if ({clk_out, tick, cfg_pend} !== {m_clk, m_tick, m_pend}) begin
                miscompares++;
                $display("FAIL reconfig_wait t=%0d got %b want %b", m_t, {clk_out, tick, cfg_pend}, {m_clk, m_tick, m_pend});
            end
            if (tick[0]) found = 1'b1;
        end
        vectors++;
        if (!found || cfg_pend[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL reconfig_apply got tick=%b pend=%b want tick=1 pend=0", found, cfg_pend[0]);
        end
        gap = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            gap++;
            if (tick[0]) found = 1'b1;
        end
        vectors++;
        if (gap !== 5) begin
            miscompares++;
            $display("FAIL reconfig_half_period got %0d want 5", gap);
        end
    endtask

    task automatic test_div0_badch();
        int ticks;
        cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd0;
        step();
        cfg_wr = 1'b0;
        vectors++;
        if (cfg_pend[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL div0_pend_set got %b want 1", cfg_pend[1]);
        end
        step();
        vectors++;
        if (cfg_pend[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL div0_pend_clear got %b want 0", cfg_pend[1]);
        end
        ch_en = 3'b011;
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            vectors++;
            if ({clk_out, tick, cfg_pend} !== {m_clk, m_tick, m_pend}) begin
                miscompares++;
                $display("FAIL div0 t=%0d got %b want %b", m_t, {clk_out, tick, cfg_pend}, {m_clk, m_tick, m_pend});
            end
            if (tick[1]) ticks++;
        end
        vectors++;
        if (ticks !== 8) begin
            miscompares++;
            $display("FAIL div0_every_cycle got %0d want 8", ticks);
        end
        cfg_wr = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd7;
        step();
        cfg_wr = 1'b0;
        vectors++;
        if (cfg_pend !== 3'b000) begin
            miscompares++;
            $display("FAIL bad_ch_pend got %b want 000", cfg_pend);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            vectors++;
            if ({clk_out, tick, cfg_pend} !== {m_clk, m_tick, m_pend}) begin
                miscompares++;
                $display("FAIL bad_ch t=%0d got %b want %b", m_t, {clk_out, tick, cfg_pend}, {m_clk, m_tick, m_pend});
            end
        end
    endtask

    task automatic test_sync();
        int coinc, first;
        logic [1:0] prev;
        ch_en = 3'b000;
        cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd2;
        step();
        cfg_ch = 2'd1; cfg_div = 8'd6;
        step();
        cfg_wr = 1'b0;
        repeat (2) step();
        ch_en = 3'b011;
        repeat ($urandom_range(15, 5)) begin
            step();
            vectors++;
            if ({clk_out, tick, cfg_pend} !== {m_clk, m_tick, m_pend}) begin
                miscompares++;
                $display("FAIL sync_pre t=%0d got %b want %b", m_t, {clk_out, tick, cfg_pend}, {m_clk, m_tick, m_pend});
            end
        end
        sync_all = 1'b1;
        step();
        sync_all = 1'b0;
        vectors++;
        if (clk_out[1:0] !== 2'b00) begin
            miscompares++;
            $display("FAIL sync_clear got %b want 00", clk_out[1:0]);
        end
        coinc = 0;
        first = -1;
        prev  = 2'b00;
        for (int i = 1; i <= 36; i++) begin
            step();
            vectors++;
            if ({clk_out, tick, cfg_pend} !== {m_clk, m_tick, m_pend}) begin
                miscompares++;
                $display("FAIL sync t=%0d got %b want %b", m_t, {clk_out, tick, cfg_pend}, {m_clk, m_tick, m_pend});
            end
            if (clk_out[0] && !prev[0] && clk_out[1] && !prev[1]) begin
                coinc++;
                if (first < 0) first = i;
            end
            prev = clk_out[1:0];
        end
        vectors++;
        if (coinc !== 3 || first !== 6) begin
            miscompares++;
            $display("FAIL sync_realign got count=%0d first=%0d want count=3 first=6", coinc, first);
        end
    endtask

    task automatic test_coincident();
        bit found, saw_pend;
        int gap;
        ch_en = 3'b001;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_t - m_start[0] + 1 >= eff(m_act[0])) found = 1'b1;
            else step();
        end
        cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd3;
        step();
        cfg_wr = 1'b0;
        vectors++;
        if (!found || tick[0] !== 1'b1 || cfg_pend[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL coincident_apply got tick=%b pend=%b want tick=1 pend=0", tick[0], cfg_pend[0]);
        end
        saw_pend = 1'b0;
        gap = 0;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            vectors++;
            if ({clk_out, tick, cfg_pend} !== {m_clk, m_tick, m_pend}) begin
                miscompares++;
                $display("FAIL coincident t=%0d got %b want %b", m_t, {clk_out, tick, cfg_pend}, {m_clk, m_tick, m_pend});
            end
            if (cfg_pend[0]) saw_pend = 1'b1;
            if (!found) gap++;
            if (tick[0]) found = 1'b1;
        end
        vectors++;
        if (saw_pend || gap !== 3) begin
            miscompares++;
            $display("FAIL coincident_next got pend=%b gap=%0d want pend=0 gap=3", saw_pend, gap);
        end
    endtask

    task automatic test_random();
        ch_en = 3'b111;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(15, 0) == 0) ch_en = 3'($urandom_range(7, 0));
            sync_all = ($urandom_range(63, 0) == 0);
            cfg_wr   = ($urandom_range(3, 0) == 0);
            cfg_ch   = 2'($urandom_range(3, 0));
            cfg_div  = 8'($urandom_range(6, 0));
            step();
            sync_all = 1'b0;
            cfg_wr   = 1'b0;
            vectors++;
            if ({clk_out, tick, cfg_pend} !== {m_clk, m_tick, m_pend}) begin
                miscompares++;
                $display("FAIL random t=%0d got %b want %b", m_t, {clk_out, tick, cfg_pend}, {m_clk, m_tick, m_pend});
            end
        end
    endtask

    task automatic test_async_reset();
        int ticks;
        ch_en = 3'b111;
        cfg_wr = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd5;
        step();
        cfg_wr = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({clk_out, tick, cfg_pend} !== '0) begin
            miscompares++;
            $display("FAIL async_reset got %b want 0", {clk_out, tick, cfg_pend});
        end
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        reset_n = 1'b1;
        model_reset();
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            vectors++;
            if ({clk_out, tick, cfg_pend} !== {m_clk, m_tick, m_pend}) begin
                miscompares++;
                $display("FAIL post_reset t=%0d got %b want %b", m_t, {clk_out, tick, cfg_pend}, {m_clk, m_tick, m_pend});
            end
            if (i < 8 && tick[2]) ticks++;
        end
        vectors++;
        if (ticks !== 2) begin
            miscompares++;
            $display("FAIL post_reset_default_div got %0d want 2", ticks);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        ch_en       = '0;
        sync_all    = 1'b0;
        cfg_wr      = 1'b0;
        cfg_ch      = '0;
        cfg_div     = '0;
        vectors     = 0;
        miscompares = 0;
        m_t         = 0;
        model_reset();
        test_reset();
        test_basic();
        test_reconfig();
        test_div0_badch();
        test_sync();
        test_coincident();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
